// File: rtl/ch_sweep_unit.sv
// ch_sweep_unit: frequency-sweep engine for one sweep-capable square channel.
// Keeps a shadow frequency, runs the sweep period timer off the frame-sequencer
// strobe and computes shadow +/- (shadow >> shift) with a bit-serial shifter.
// A pass-1 result is committed to the channel; a pass-2 result is only used
// for the overflow check. An overflow, or clearing the negate bit after a
// subtract calculation, disables the channel.
//
// Handshake: freq_wr and ch_disable are one-cycle registered strobes with no
// back-pressure; the channel must act on them in the cycle they are high.
// freq_out is valid from the freq_wr cycle and holds until the next write.
// busy is high from LOAD through the final SUM. dbg_state mirrors the FSM.
module ch_sweep_unit #(
  parameter int FREQ_W   = 11,
  parameter int SHIFT_W  = 3,
  parameter int PERIOD_W = 3
) (
  input  logic                clk,
  input  logic                apu_reset,
  input  logic                sweep_tick,
  input  logic                trigger,
  input  logic [PERIOD_W-1:0] sweep_period,
  input  logic                sweep_negate,
  input  logic [SHIFT_W-1:0]  sweep_shift,
  input  logic [FREQ_W-1:0]   freq_in,
  output logic [FREQ_W-1:0]   freq_out,
  output logic                freq_wr,
  output logic                ch_disable,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_SUM   = 2'd3
  } state_t;

  // A period field of 0 reloads the timer with 2^PERIOD_W.
  localparam logic [PERIOD_W:0] RELOAD_MAX = {1'b1, {PERIOD_W{1'b0}}};
  localparam logic [PERIOD_W:0] TIMER_ONE  = {{PERIOD_W{1'b0}}, 1'b1};
  localparam logic [SHIFT_W-1:0] CNT_ONE   = {{(SHIFT_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_state_nxt;
  logic [FREQ_W-1:0]   r_shadow;
  logic [FREQ_W-1:0]   r_shifter;
  logic [SHIFT_W-1:0]  r_cnt;
  logic [PERIOD_W:0]   r_timer;
  logic                r_en;
  logic                r_neg_used;
  logic                r_pass2;
  logic                r_neg_d1;
  logic                r_neg_d2;
  logic [FREQ_W-1:0]   r_freq_out;
  logic                r_freq_wr;
  logic                r_ch_disable;

  logic [PERIOD_W:0]   w_reload;
  logic                w_period_nz;
  logic                w_shift_nz;
  logic                w_expire;
  logic                w_start;
  logic [FREQ_W:0]     w_sum;
  logic                w_ovf;
  logic                w_write;
  logic                w_commit;
  logic                w_ovf_dis;
  logic                w_neg_clear;

  assign w_period_nz = (sweep_period != '0);
  assign w_shift_nz  = (sweep_shift != '0);
  assign w_reload    = w_period_nz ? {1'b0, sweep_period} : RELOAD_MAX;

  // A trigger in the same cycle swallows the tick entirely.
  assign w_expire = sweep_tick && !trigger && (r_timer <= TIMER_ONE);
  assign w_start  = w_expire && r_en && w_period_nz && (r_state == S_IDLE);

  // Subtract never goes negative: shifter is always shadow shifted right.
  assign w_sum = sweep_negate ? ({1'b0, r_shadow} - {1'b0, r_shifter})
                              : ({1'b0, r_shadow} + {1'b0, r_shifter});
  assign w_ovf = !sweep_negate && w_sum[FREQ_W];

  // Negate 1->0 seen on the registered copies; trigger takes precedence.
  assign w_neg_clear = r_neg_used && r_neg_d2 && !r_neg_d1 && !trigger;

  // A negate-clear disable in the same cycle as a write suppresses the write,
  // so freq_wr and ch_disable can never both be high.
  assign w_commit = w_write && !w_neg_clear;

  // Next-state logic and SUM decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_write     = 1'b0;
    w_ovf_dis   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_state_nxt = w_shift_nz ? S_SHIFT : S_SUM;
      end
      S_SHIFT: begin
        if (r_cnt <= CNT_ONE) w_state_nxt = S_SUM;
      end
      S_SUM: begin
        if (w_ovf) begin
          w_ovf_dis   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (!r_pass2 && w_shift_nz) begin
          w_write     = 1'b1;
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Trigger aborts anything in flight and may start a check-only pass.
    if (trigger) begin
      w_write     = 1'b0;
      w_ovf_dis   = 1'b0;
      w_state_nxt = w_shift_nz ? S_LOAD : S_IDLE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge apu_reset) begin
    if (apu_reset) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Bit-serial shifter and shift counter.
  always_ff @(posedge clk or posedge apu_reset) begin
    if (apu_reset) begin
      r_shifter <= '0;
      r_cnt     <= '0;
    end else if (r_state == S_LOAD) begin
      r_shifter <= r_shadow;
      r_cnt     <= sweep_shift;
    end else if (r_state == S_SHIFT) begin
      r_shifter <= r_shifter >> 1;
      r_cnt     <= r_cnt - CNT_ONE;
    end
  end

  // Sweep period timer.
  always_ff @(posedge clk or posedge apu_reset) begin
    if (apu_reset) begin
      r_timer <= '0;
    end else if (trigger) begin
      r_timer <= w_reload;
    end else if (sweep_tick) begin
      if (r_timer > TIMER_ONE) r_timer <= r_timer - TIMER_ONE;
      else                     r_timer <= w_reload;
    end
  end

  // Shadow frequency, enable, negate bookkeeping and pass tracking.
  always_ff @(posedge clk or posedge apu_reset) begin
    if (apu_reset) begin
      r_shadow   <= '0;
      r_en       <= 1'b0;
      r_neg_used <= 1'b0;
      r_pass2    <= 1'b0;
    end else if (trigger) begin
      r_shadow   <= freq_in;
      r_en       <= w_period_nz || w_shift_nz;
      r_neg_used <= 1'b0;
      r_pass2    <= 1'b1;
    end else begin
      if (w_commit)                 r_shadow   <= w_sum[FREQ_W-1:0];
      if (w_ovf_dis || w_neg_clear) r_en       <= 1'b0;
      if ((r_state == S_SUM) && sweep_negate) r_neg_used <= 1'b1;
      if (w_start)                  r_pass2    <= 1'b0;
      else if (w_write)             r_pass2    <= 1'b1;
    end
  end

  // Delayed copies of the negate bit for falling-edge detection.
  always_ff @(posedge clk or posedge apu_reset) begin
    if (apu_reset) begin
      r_neg_d1 <= 1'b0;
      r_neg_d2 <= 1'b0;
    end else begin
      r_neg_d1 <= sweep_negate;
      r_neg_d2 <= r_neg_d1;
    end
  end

  // Registered output strobes and committed frequency.
  always_ff @(posedge clk or posedge apu_reset) begin
    if (apu_reset) begin
      r_freq_out   <= '0;
      r_freq_wr    <= 1'b0;
      r_ch_disable <= 1'b0;
    end else begin
      r_freq_wr    <= w_commit;
      r_ch_disable <= w_ovf_dis || w_neg_clear;
      if (w_commit) r_freq_out <= w_sum[FREQ_W-1:0];
    end
  end

  assign freq_out   = r_freq_out;
  assign freq_wr    = r_freq_wr;
  assign ch_disable = r_ch_disable;
  assign busy       = (r_state != S_IDLE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_ch_sweep_unit.sv
// Directed bench for ch_sweep_unit: hand-computed sweep results, strobe
// cycle positions and disable behaviour.
module tb_ch_sweep_unit;

  logic        clk = 1'b0;
  logic        apu_reset;
  logic        sweep_tick;
  logic        trigger;
  logic [2:0]  sweep_period;
  logic        sweep_negate;
  logic [2:0]  sweep_shift;
  logic [10:0] freq_in;
  logic [10:0] freq_out;
  logic        freq_wr;
  logic        ch_disable;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-window observations.
  int   wr_cnt, wr_at, dis_cnt, dis_at, both_cnt, busy_cnt;
  logic busy_hist [0:63];

  ch_sweep_unit dut (
    .clk          (clk),
    .apu_reset    (apu_reset),
    .sweep_tick   (sweep_tick),
    .trigger      (trigger),
    .sweep_period (sweep_period),
    .sweep_negate (sweep_negate),
    .sweep_shift  (sweep_shift),
    .freq_in      (freq_in),
    .freq_out     (freq_out),
    .freq_wr      (freq_wr),
    .ch_disable   (ch_disable),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trigger(input logic [10:0] f);
    freq_in = f;
    trigger = 1'b1;
    cyc();
    trigger = 1'b0;
  endtask

  task automatic pulse_tick();
    sweep_tick = 1'b1;
    cyc();
    sweep_tick = 1'b0;
  endtask

  // Observe cycles 1..n after an event sampled in cycle 0.
  task automatic window(input int n);
    wr_cnt = 0; wr_at = 0; dis_cnt = 0; dis_at = 0; both_cnt = 0; busy_cnt = 0;
    for (int k = 0; k < 64; k++) busy_hist[k] = 1'b0;
    for (int k = 1; k <= n; k++) begin
      busy_hist[k] = busy;
      if (busy) busy_cnt++;
      if (freq_wr) begin
        wr_cnt++;
        if (wr_at == 0) wr_at = k;
      end
      if (ch_disable) begin
        dis_cnt++;
        if (dis_at == 0) dis_at = k;
      end
      if (freq_wr && ch_disable) both_cnt++;
      cyc();
    end
  endtask

  initial begin
    int busy_total;
    // Reset
    apu_reset    = 1'b1;
    sweep_tick   = 1'b0;
    trigger      = 1'b0;
    sweep_period = 3'd1;
    sweep_negate = 1'b0;
    sweep_shift  = 3'd1;
    freq_in      = 11'h000;
    repeat (3) cyc();
    check_eq("rst_freq_out", freq_out, 0);
    check_eq("rst_freq_wr", freq_wr, 0);
    check_eq("rst_ch_disable", ch_disable, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_state", dbg_state, 0);
    apu_reset = 1'b0;
    cyc();

    // Add: 0x100 + 0x080 = 0x180; pass 2 (0x240) writes nothing
    sweep_period = 3'd1; sweep_shift = 3'd1; sweep_negate = 1'b0;
    pulse_trigger(11'h100);
    window(10);
    check_eq("add_trig_wr", wr_cnt, 0);
    check_eq("add_trig_dis", dis_cnt, 0);
    pulse_tick();
    window(10);
    check_eq("add_wr_cnt", wr_cnt, 1);
    check_eq("add_wr_at", wr_at, 4);
    check_eq("add_freq_out", freq_out, 11'h180);
    check_eq("add_dis", dis_cnt, 0);
    check_eq("add_busy_c1", busy_hist[1], 1);
    check_eq("add_busy_c6", busy_hist[6], 1);
    check_eq("add_busy_c7", busy_hist[7], 0);
    check_eq("add_both", both_cnt, 0);

    // Overflow on tick: 0x500 -> 0x780 written, pass 2 0xB40 overflows
    pulse_trigger(11'h500);
    window(10);
    check_eq("ovt_trig_dis", dis_cnt, 0);
    pulse_tick();
    window(12);
    check_eq("ovt_wr_at", wr_at, 4);
    check_eq("ovt_freq_out", freq_out, 11'h780);
    check_eq("ovt_dis_cnt", dis_cnt, 1);
    check_eq("ovt_dis_at", dis_at, 7);
    check_eq("ovt_both", both_cnt, 0);
    pulse_tick();
    window(10);
    check_eq("ovt_after_busy", busy_cnt, 0);
    check_eq("ovt_after_wr", wr_cnt, 0);
    check_eq("ovt_after_dis", dis_cnt, 0);

    // Overflow at 0x7F0: 0x7F0 + 0x3F8 = 0xBE8 on the trigger check
    pulse_trigger(11'h7F0);
    window(10);
    check_eq("ov7_dis_at", dis_at, 4);
    check_eq("ov7_dis_cnt", dis_cnt, 1);
    check_eq("ov7_wr", wr_cnt, 0);
    pulse_tick();
    window(10);
    check_eq("ov7_tick_busy", busy_cnt, 0);
    check_eq("ov7_tick_strobes", wr_cnt + dis_cnt, 0);

    // Trigger check 0x600 + 0x300 = 0x900, then shift 0 does nothing
    pulse_trigger(11'h600);
    window(10);
    check_eq("trg_dis_at", dis_at, 4);
    check_eq("trg_wr", wr_cnt, 0);
    sweep_shift = 3'd0;
    pulse_trigger(11'h600);
    window(10);
    check_eq("trg0_busy", busy_cnt, 0);
    check_eq("trg0_strobes", wr_cnt + dis_cnt, 0);
    check_eq("trg0_freq_out", freq_out, 11'h780);

    // Subtract: 0x400 - 0x100 = 0x300, then negate-clear disable
    sweep_shift = 3'd2; sweep_negate = 1'b1; sweep_period = 3'd1;
    pulse_trigger(11'h400);
    window(10);
    check_eq("sub_trig_strobes", wr_cnt + dis_cnt, 0);
    pulse_tick();
    window(12);
    check_eq("sub_wr_at", wr_at, 5);
    check_eq("sub_freq_out", freq_out, 11'h300);
    check_eq("sub_dis", dis_cnt, 0);
    check_eq("sub_busy_c8", busy_hist[8], 1);
    check_eq("sub_busy_c9", busy_hist[9], 0);
    sweep_negate = 1'b0;
    cyc();
    window(6);
    check_eq("negclr_dis_cnt", dis_cnt, 1);
    check_eq("negclr_dis_at", dis_at, 2);
    // Same edge with no calculation since the trigger: no disable
    sweep_negate = 1'b1; sweep_shift = 3'd0;
    pulse_trigger(11'h400);
    window(5);
    sweep_negate = 1'b0;
    cyc();
    window(6);
    check_eq("negclr_nocalc_dis", dis_cnt, 0);

    // Period 0: timer reloads to 8, expiries never start a calculation
    sweep_period = 3'd0; sweep_shift = 3'd1; sweep_negate = 1'b0;
    pulse_trigger(11'h010);
    window(8);
    check_eq("p0_trig_strobes", wr_cnt + dis_cnt, 0);
    busy_total = 0;
    for (int t = 0; t < 10; t++) begin
      pulse_tick();
      window(4);
      busy_total += busy_cnt;
    end
    check_eq("p0_no_busy", busy_total, 0);
    // Timer now 6 after reload to 8 at tick 8; five more ticks reach 1
    sweep_period = 3'd1;
    busy_total = 0;
    for (int t = 0; t < 5; t++) begin
      pulse_tick();
      window(4);
      busy_total += busy_cnt;
    end
    check_eq("p0_pre_expire_busy", busy_total, 0);
    pulse_tick();
    window(8);
    check_eq("p0_expire_busy", busy_hist[1], 1);
    check_eq("p0_wr_at", wr_at, 4);
    check_eq("p0_freq_out", freq_out, 11'h018);

    // Trigger during SHIFT aborts, old result never written
    sweep_period = 3'd1; sweep_shift = 3'd3;
    pulse_trigger(11'h100);
    window(12);
    pulse_tick();
    cyc();
    cyc();
    check_eq("abort_in_shift", dbg_state, 2);
    pulse_trigger(11'h200);
    window(20);
    check_eq("abort_wr", wr_cnt, 0);
    check_eq("abort_dis", dis_cnt, 0);
    check_eq("abort_freq_out", freq_out, 11'h018);
    pulse_tick();
    window(12);
    check_eq("abort_new_wr_at", wr_at, 6);
    check_eq("abort_new_freq", freq_out, 11'h240);

    // Reset asserted mid-SHIFT
    sweep_shift = 3'd7;
    pulse_trigger(11'h100);
    cyc();
    cyc();
    check_eq("rstmid_in_shift", dbg_state, 2);
    apu_reset = 1'b1;
    #1;
    check_eq("rstmid_freq_out", freq_out, 0);
    check_eq("rstmid_busy", busy, 0);
    check_eq("rstmid_wr", freq_wr, 0);
    check_eq("rstmid_dis", ch_disable, 0);
    cyc();
    apu_reset = 1'b0;
    window(25);
    check_eq("rstmid_after_busy", busy_cnt, 0);
    check_eq("rstmid_after_strobes", wr_cnt + dis_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
